// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Shared constants and types for the Sirius instruction-fetch stage.
//   RstEnable   : active level of the reset (1 = asserted)
//   ZeroWord    : 32-bit zero, used for NOP bubbles
//   InstAddrBus : width of an instruction address
//   InstBus     : width of an instruction word
//   FetchDepth  : default outstanding-plus-buffered fetch capacity
//   ResetPC     : default first fetch address
// ----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam logic            RstEnable   = 1'b1;
    localparam logic [31:0]     ZeroWord    = 32'h0000_0000;
    localparam int unsigned     InstAddrBus = 32;
    localparam int unsigned     InstBus     = 32;
    localparam int unsigned     FetchDepth  = 2;
    localparam logic [31:0]     ResetPC     = 32'h0000_0000;

    // One buffered fetch result as handed to IF/ID.
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used twice by if_fetch (issued-address tracking and
// instruction buffering).
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active high
//   i_flush  : synchronous clear of all entries (wins over push/pop)
//   i_push   : write i_wdata (ignored when full unless popping the same cycle)
//   i_wdata  : write data
//   i_pop    : drop the head entry (ignored when empty)
//   o_rdata  : head entry
//   o_count  : number of stored entries
//   o_empty  : no entries stored
// ----------------------------------------------------------------------------
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PW'(1);
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: issues sequential word reads to instruction ROM,
// buffers returned words and presents one {pc, inst} pair per cycle to IF/ID.
// Branch redirects flush the buffer and discard in-flight wrong-path reads.
//   clk              : clock, rising edge
//   rst              : asynchronous reset, active high
//   stall_i          : IF/ID does not take an instruction this cycle
//   branch_flag_i    : redirect request from ID
//   branch_target_i  : redirect address (low two bits ignored)
//   rom_req_o        : ROM read request
//   rom_addr_o       : ROM word address
//   rom_ready_i      : ROM accepts the request this cycle
//   rom_rvalid_i     : ROM read data valid (in request order)
//   rom_rdata_i      : ROM read data
//   if_pc_o          : PC of the presented instruction (0 when not valid)
//   if_inst_o        : presented instruction (0 when not valid)
//   if_valid_o       : presented pair is real
// ----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPC,
    parameter int unsigned DEPTH    = FetchDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_target_i,
    output logic                   rom_req_o,
    output logic [31:0]            rom_addr_o,
    input  logic                   rom_ready_i,
    input  logic                   rom_rvalid_i,
    input  logic [31:0]            rom_rdata_i,
    output logic [InstAddrBus-1:0] if_pc_o,
    output logic [InstBus-1:0]     if_inst_o,
    output logic                   if_valid_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned UW = CW + 1;

    logic [31:0]  r_pc_next;
    logic [CW-1:0] r_drop;

    // The address FIFO holds exactly the outstanding requests, so its count
    // is the outstanding-request counter.
    logic [CW-1:0] w_outst;
    logic [CW-1:0] w_inst_count;
    logic          w_addr_empty;
    logic          w_inst_empty;
    logic [31:0]   w_resp_addr;
    fetch_entry_t  w_inst_head;
    fetch_entry_t  w_inst_wdata;
    logic          w_in_reset;
    logic          w_accept;
    logic          w_resp;
    logic          w_drop_now;
    logic          w_capture;
    logic          w_pop;
    logic [UW-1:0] w_used;

    assign w_in_reset = (rst == RstEnable);
    assign w_resp     = rom_rvalid_i && !w_addr_empty;
    assign w_drop_now = w_resp && (r_drop != '0);
    assign w_capture  = w_resp && (r_drop == '0) && !branch_flag_i;
    // A branch discards the presented entry through the flush, not a pop.
    assign w_pop      = if_valid_o && !stall_i && !branch_flag_i;

    // Credits in use after this cycle's departures: an entry leaving to IF/ID
    // or a wrong-path response being discarded frees its slot in time for a
    // new request, which keeps a one-cycle ROM at full rate with DEPTH=2.
    assign w_used = {1'b0, w_outst} + {1'b0, w_inst_count}
                  - UW'(w_pop) - UW'(w_drop_now);

    assign rom_req_o  = !w_in_reset && !branch_flag_i && (w_used < UW'(DEPTH));
    assign rom_addr_o = r_pc_next;
    assign w_accept   = rom_req_o && rom_ready_i;

    assign w_inst_wdata = '{pc: w_resp_addr, inst: rom_rdata_i};

    assign if_valid_o = !w_inst_empty;
    assign if_pc_o    = if_valid_o ? w_inst_head.pc   : ZeroWord;
    assign if_inst_o  = if_valid_o ? w_inst_head.inst : ZeroWord;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_pc_next <= align_word(RESET_PC);
            r_drop    <= '0;
        end else if (branch_flag_i) begin
            r_pc_next <= align_word(branch_target_i);
            // A response landing in the branch cycle is already gone.
            r_drop    <= w_outst - CW'(w_resp);
        end else begin
            if (w_accept) begin
                r_pc_next <= r_pc_next + 32'd4;
            end
            if (w_drop_now) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_wdata (r_pc_next),
        .i_pop   (w_resp),
        .o_rdata (w_resp_addr),
        .o_count (w_outst),
        .o_empty (w_addr_empty)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (branch_flag_i),
        .i_push  (w_capture),
        .i_wdata (w_inst_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_inst_head),
        .o_count (w_inst_count),
        .o_empty (w_inst_empty)
    );

endmodule
